// File: rtl/draw_sched_pkg.sv
// Shared definitions for the draw scheduler slice.
// Holds the FSM state encoding, the requester count and index constants
// (rooms 0-4 plus the all-locked overlay) and the default watchdog limit.
package draw_sched_pkg;

  localparam int NUM_REQ = 6;
  // draw_sel is a fixed 3-bit field on the VGA datapath side.
  localparam int SEL_W = 3;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd20000;

  localparam logic [SEL_W-1:0] ROOM0     = 3'd0;
  localparam logic [SEL_W-1:0] ROOM1     = 3'd1;
  localparam logic [SEL_W-1:0] ROOM2     = 3'd2;
  localparam logic [SEL_W-1:0] ROOM3     = 3'd3;
  localparam logic [SEL_W-1:0] ROOM4     = 3'd4;
  localparam logic [SEL_W-1:0] ALLLOCKED = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    DRAW  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   pending    - one bit per requester with an outstanding request
//   last_grant - index granted most recently
//   winner     - first pending index found searching upward from
//                last_grant+1 with wraparound (0 when nothing pending)
//   any        - at least one request is pending
module rr_arbiter
  import draw_sched_pkg::*;
#(
  parameter int NUM_REQ = draw_sched_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [SEL_W-1:0]   last_grant,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // One extra bit so last_grant + offset cannot overflow before the wrap.
  localparam int CW = SEL_W + 1;

  logic [CW-1:0] cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    // Offsets 1..NUM_REQ visit every index once; the last one revisited is
    // last_grant itself, so a lone requester can win twice in a row.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!any && pending[cand[SEL_W-1:0]]) begin
        any    = 1'b1;
        winner = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Serialises draw requests from the rooms / all-locked overlay and full-screen
// clears onto a single VGA drawing datapath, with a per-operation watchdog.
// Ports:
//   clock, reset    - sole clock; synchronous active-high reset
//   req             - per-requester draw request, each high cycle latches one
//   clear_req       - request a full-screen clear (served ahead of any draw)
//   countDone       - datapath reports the current draw/clear finished
//   draw_start      - one-cycle pulse launching a draw of draw_sel
//   draw_sel        - granted requester, stable from grant through DONE
//   clearinitsignal - high for the whole clear operation
//   done_pulse      - one-cycle pulse as each draw or clear ends
//   busy            - scheduler is not idle
//   pending         - outstanding draw requests
//   timeout_err     - sticky, set whenever the watchdog aborts an operation
//   state           - current FSM state, exported for observation
//
// Handshake: requests are level-sampled events, not valid/ready pairs; every
// cycle req[i] or clear_req is high at a clock edge latches one pending
// request, and there is no back-pressure. The datapath side is started by
// draw_start (or the rising of clearinitsignal) and closes the operation by
// raising countDone; countDone outside DRAW/CLEAR is ignored.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int          NUM_REQ = draw_sched_pkg::NUM_REQ,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clear_req,
  input  logic               countDone,
  output logic               draw_start,
  output logic [SEL_W-1:0]   draw_sel,
  output logic               clearinitsignal,
  output logic               done_pulse,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout_err,
  output state_t             state
);

  logic             clear_pending;
  logic [SEL_W-1:0] last_grant;
  logic [15:0]      watchdog;
  logic [SEL_W-1:0] arb_winner;
  logic             arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= '0;
      clear_pending   <= 1'b0;
      // Starting from the top index makes requester 0 the first winner.
      last_grant      <= SEL_W'(NUM_REQ - 1);
      watchdog        <= '0;
      timeout_err     <= 1'b0;
      draw_sel        <= '0;
      draw_start      <= 1'b0;
      clearinitsignal <= 1'b0;
      done_pulse      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      draw_start    <= 1'b0;
      done_pulse    <= 1'b0;
      pending       <= pending | req;
      clear_pending <= clear_pending | clear_req;

      case (state)
        IDLE: begin
          if (clear_pending) begin
            state           <= CLEAR;
            busy            <= 1'b1;
            clearinitsignal <= 1'b1;
            watchdog        <= '0;
            // A clear_req on this very edge is a fresh request and survives.
            clear_pending   <= clear_req;
          end else if (arb_any) begin
            state      <= GRANT;
            busy       <= 1'b1;
            draw_start <= 1'b1;
            draw_sel   <= arb_winner;
          end
        end

        GRANT: begin
          state                <= DRAW;
          watchdog             <= '0;
          last_grant           <= draw_sel;
          // Served request drops unless the requester re-asserts right now.
          pending[draw_sel]    <= req[draw_sel];
        end

        DRAW, CLEAR: begin
          // countDone wins a tie with expiry: that is a normal completion.
          if (countDone || (watchdog == TIMEOUT - 16'd1)) begin
            state           <= DONE;
            done_pulse      <= 1'b1;
            clearinitsignal <= 1'b0;
            if (!countDone) timeout_err <= 1'b1;
          end else if (watchdog != 16'hFFFF) begin
            watchdog <= watchdog + 16'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
